// File: rtl/modn_tick_counter_if.sv
// Control and status bundle for modn_tick_counter: step/load controls in, count and strobes out.
interface modn_tick_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ext_tick;
    logic             tick;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             carry;

    modport master (
        output en, up, load, load_val, ext_tick,
        input  tick, q, tc, carry
    );

    modport slave (
        input  en, up, load, load_val, ext_tick,
        output tick, q, tc, carry
    );
endinterface

// File: rtl/modn_tick_counter.sv
// Modulo-N up/down counter with clock-enable prescaler, clamped synchronous load,
// terminal count and a one-cycle carry/borrow pulse for cascading stages.
module modn_tick_counter #(
    parameter int DIV          = 50_000_000,
    parameter int MODULUS      = 12,
    parameter int WIDTH        = 4,
    parameter int USE_EXT_TICK = 0
) (
    input  logic               clk,
    input  logic               rst,
    modn_tick_counter_if.slave bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRE_MAX = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_V   = (WIDTH + 1)'(MODULUS);

    logic [PW-1:0]    r_pre;
    logic             r_tick;
    logic [WIDTH-1:0] r_q;
    logic             r_carry;
    logic             w_step;
    logic [WIDTH-1:0] w_load_q;

    // A tick seen while en=0 is discarded, so tick is cleared rather than held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (USE_EXT_TICK != 0) begin
            r_pre  <= '0;
            r_tick <= bus.ext_tick & bus.en;
        end else if (bus.en) begin
            if (r_pre == PRE_MAX) begin
                r_pre  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_pre  <= r_pre + 1'b1;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign w_step   = r_tick & bus.en;
    assign w_load_q = ({1'b0, bus.load_val} < MOD_V) ? bus.load_val : Q_MAX;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q     <= '0;
            r_carry <= 1'b0;
        end else if (bus.load) begin
            r_q     <= w_load_q;
            r_carry <= 1'b0;
        end else if (w_step) begin
            if (bus.up) begin
                if (r_q == Q_MAX) begin
                    r_q     <= '0;
                    r_carry <= 1'b1;
                end else begin
                    r_q     <= r_q + 1'b1;
                    r_carry <= 1'b0;
                end
            end else begin
                if (r_q == '0) begin
                    r_q     <= Q_MAX;
                    r_carry <= 1'b1;
                end else begin
                    r_q     <= r_q - 1'b1;
                    r_carry <= 1'b0;
                end
            end
        end else begin
            r_carry <= 1'b0;
        end
    end

    assign bus.tick  = r_tick;
    assign bus.q     = r_q;
    assign bus.carry = r_carry;
    assign bus.tc    = (bus.up & (r_q == Q_MAX)) | (~bus.up & (r_q == '0));
endmodule

// File: tb/tb_modn_tick_counter.sv
// Directed bench: single DIV=4 mod-12 counter plus a DIV=2 mod-12 -> mod-5 cascade.
module tb_modn_tick_counter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    modn_tick_counter_if #(.WIDTH(4)) if0 ();
    modn_tick_counter_if #(.WIDTH(4)) ifa ();
    modn_tick_counter_if #(.WIDTH(3)) ifb ();

    modn_tick_counter #(.DIV(4), .MODULUS(12), .WIDTH(4), .USE_EXT_TICK(0))
        u_dut (.clk(clk), .rst(rst), .bus(if0));
    modn_tick_counter #(.DIV(2), .MODULUS(12), .WIDTH(4), .USE_EXT_TICK(0))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    modn_tick_counter #(.DIV(1), .MODULUS(5), .WIDTH(3), .USE_EXT_TICK(1))
        u_b (.clk(clk), .rst(rst), .bus(ifb));

    assign ifb.ext_tick = ifa.carry;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Returns negedges waited until if0.tick is high; returns at once if already high.
    task automatic wait_tick(output int cyc);
        cyc = 0;
        while (!if0.tick && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("tick_seen", int'(if0.tick), 1);
    endtask

    initial begin
        int cyc;
        int cnt;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        if0.en = 1'b0; if0.up = 1'b1; if0.load = 1'b0; if0.load_val = '0; if0.ext_tick = 1'b0;
        ifa.en = 1'b0; ifa.up = 1'b1; ifa.load = 1'b0; ifa.load_val = '0; ifa.ext_tick = 1'b0;
        ifb.en = 1'b1; ifb.up = 1'b1; ifb.load = 1'b0; ifb.load_val = '0;

        repeat (3) @(negedge clk);
        check("rst_q", int'(if0.q), 0);
        check("rst_tick", int'(if0.tick), 0);
        check("rst_carry", int'(if0.carry), 0);

        // first tick 4 enabled cycles after release
        rst = 1'b1;
        if0.en = 1'b1;
        wait_tick(cyc);
        check("first_tick_lat", cyc, 4);
        @(negedge clk);
        check("first_step_q", int'(if0.q), 1);
        check("tick_one_cycle", int'(if0.tick), 0);
        for (int k = 2; k <= 5; k++) begin
            wait_tick(cyc);
            @(negedge clk);
            check("count_to5", int'(if0.q), k);
        end

        // asynchronous reset between edges
        #2 rst = 1'b0;
        #1;
        check("async_rst_q", int'(if0.q), 0);
        check("async_rst_tick", int'(if0.tick), 0);
        check("async_rst_carry", int'(if0.carry), 0);
        @(negedge clk);
        rst = 1'b1;
        wait_tick(cyc);
        check("post_rst_tick_lat", cyc, 4);
        @(negedge clk);
        check("post_rst_q", int'(if0.q), 1);

        // up count to wrap
        for (int k = 2; k <= 11; k++) begin
            wait_tick(cyc);
            check("tick_period", cyc, 3);
            @(negedge clk);
            check("up_q", int'(if0.q), k);
        end
        check("tc_up_11", int'(if0.tc), 1);
        wait_tick(cyc);
        @(negedge clk);
        check("up_wrap_q", int'(if0.q), 0);
        check("up_wrap_carry", int'(if0.carry), 1);
        check("up_wrap_tc", int'(if0.tc), 0);
        @(negedge clk);
        check("up_carry_len", int'(if0.carry), 0);

        // down wrap
        if0.up = 1'b0;
        #1;
        check("tc_down_0", int'(if0.tc), 1);
        wait_tick(cyc);
        @(negedge clk);
        check("down_wrap_q", int'(if0.q), 11);
        check("down_wrap_carry", int'(if0.carry), 1);
        check("down_tc_11", int'(if0.tc), 0);
        @(negedge clk);
        check("down_carry_len", int'(if0.carry), 0);
        wait_tick(cyc);
        @(negedge clk);
        check("down_q10", int'(if0.q), 10);
        wait_tick(cyc);
        @(negedge clk);
        check("down_q9", int'(if0.q), 9);

        // loads
        if0.load = 1'b1; if0.load_val = 4'd7;
        @(negedge clk);
        if0.load = 1'b0;
        check("load_7", int'(if0.q), 7);
        if0.load = 1'b1; if0.load_val = 4'd14;
        @(negedge clk);
        if0.load = 1'b0;
        check("load_clamp", int'(if0.q), 11);
        if0.up = 1'b1;
        wait_tick(cyc);
        check("pre_coinc_q", int'(if0.q), 11);
        if0.load = 1'b1; if0.load_val = 4'd3;
        @(negedge clk);
        if0.load = 1'b0;
        check("load_vs_step_q", int'(if0.q), 3);
        check("load_vs_step_carry", int'(if0.carry), 0);
        if0.en = 1'b0;
        if0.load = 1'b1; if0.load_val = 4'd6;
        @(negedge clk);
        if0.load = 1'b0;
        check("load_en0", int'(if0.q), 6);
        if0.en = 1'b1;

        // freeze mid-prescale: phase resumes
        wait_tick(cyc);
        @(negedge clk);
        check("pre_freeze_q", int'(if0.q), 7);
        if0.en = 1'b0;
        repeat (10) @(negedge clk);
        check("freeze_q", int'(if0.q), 7);
        check("freeze_tick", int'(if0.tick), 0);
        if0.en = 1'b1;
        wait_tick(cyc);
        check("resume_phase", cyc, 3);

        // freeze on a tick cycle: that step is lost
        if0.en = 1'b0;
        repeat (10) @(negedge clk);
        check("lost_tick", int'(if0.tick), 0);
        check("lost_step_q", int'(if0.q), 7);
        if0.en = 1'b1;
        wait_tick(cyc);
        check("after_lost_lat", cyc, 4);
        check("after_lost_q", int'(if0.q), 7);
        @(negedge clk);
        check("after_lost_step", int'(if0.q), 8);

        // cascade
        ifa.en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifa.carry) break;
            if (ifa.tick) cnt++;
        end
        check("casc_a_wrap_seen", int'(ifa.carry), 1);
        check("casc_a_steps", cnt, 12);
        check("casc_a_q0", int'(ifa.q), 0);
        check("casc_b_q_t0", int'(ifb.q), 0);
        @(negedge clk);
        if (ifa.tick) cnt++;
        check("casc_b_q_t1", int'(ifb.q), 0);
        @(negedge clk);
        if (ifa.tick) cnt++;
        check("casc_b_q_t2", int'(ifb.q), 1);
        for (int i = 0; i < 400 && cnt < 60; i++) begin
            @(negedge clk);
            if (ifa.tick) cnt++;
        end
        check("casc_a_60_steps", cnt, 60);
        check("casc_b_before", int'(ifb.q), 4);
        @(negedge clk);
        check("casc_a_final", int'(ifa.q), 0);
        check("casc_a_final_carry", int'(ifa.carry), 1);
        repeat (2) @(negedge clk);
        check("casc_b_final", int'(ifb.q), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
